ssd_scan_driver: RTL and testbench

Eight-digit seven-segment display scanner that sits directly downstream of the counter/barrel-shifter datapath. It takes a 32-bit value (eight hex nibbles), snapshots it at frame boundaries to prevent tearing, and time-multiplexes it onto the board's shared active-low segment bus and eight active-low anodes. The top level replaces its inline display logic with this block.

---
 rtl/ssd_scan_if.sv | 28 ++
 rtl/ssd_scan_driver.sv | 118 +++++++++++
 tb/tb_ssd_scan_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// Display scanner bus: value/strobe/blank in, segments/anodes/frame out.
// master drives the value side, slave is the scanner.
interface ssd_scan_if;
  logic [31:0] scan_data;
  logic        scan_valid;
  logic        scan_blank;
  logic [6:0]  scan_ssd;
  logic [7:0]  scan_an;
  logic        scan_frame;

  modport master (
    output scan_data,
    output scan_valid,
    output scan_blank,
    input  scan_ssd,
    input  scan_an,
    input  scan_frame
  );

  modport slave (
    input  scan_data,
    input  scan_valid,
    input  scan_blank,
    output scan_ssd,
    output scan_an,
    output scan_frame
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Eight-digit multiplexed 7-seg scanner with frame-boundary commit.
// Optional leading-zero blanking when SSD_LZ_BLANK_EN is defined.
module ssd_scan_driver #(
  parameter int CLK = 100_000
) (
  input  logic      scan_port_clk,
  input  logic      scan_port_rst,
  ssd_scan_if.slave scan
);

  localparam int CW = (CLK > 1) ? $clog2(CLK) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK - 1);

  logic [CW-1:0] count_q, count_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   pending_q, pending_d;
  logic [31:0]   disp_q, disp_d;
  logic          pend_q, pend_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    ssd_q, ssd_d;
  logic          frame_q, frame_d;

  logic       tick;
  logic       wrap;
  logic       lz;
  logic       blank;
  logic [3:0] nib;

  // Active-low hex glyphs, bit6..0 = g..a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Tick/index advance, pending capture, commit and output staging.
  always_comb begin
    tick      = (count_q == TOP);
    wrap      = tick && (idx_q == 3'd7);
    count_d   = tick ? '0 : count_q + CW'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    disp_d    = disp_q;
    // Valid is applied before commit so a coincident strobe wins.
    if (scan.scan_valid) begin
      pending_d = scan.scan_data;
      pend_d    = 1'b1;
    end
    if (wrap && pend_d) begin
      disp_d = pending_d;
      pend_d = 1'b0;
    end
    nib = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SSD_LZ_BLANK_EN
    begin : lz_blk
      logic [2:0] msn;
      msn = 3'd0;
      for (int k = 1; k < 8; k++) begin
        if (disp_q[k*4 +: 4] != 4'd0) msn = 3'(k);
      end
      lz = (idx_q > msn);
    end
`else
    lz = 1'b0;
`endif
    blank   = scan.scan_blank || lz;
    an_d    = blank ? 8'hFF : ~(8'b1 << idx_q);
    ssd_d   = blank ? 7'h7F : hex7(nib);
    frame_d = wrap;
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge scan_port_clk or negedge scan_port_rst) begin
    if (!scan_port_rst) begin
      count_q   <= '0;
      idx_q     <= 3'd0;
      pending_q <= 32'd0;
      disp_q    <= 32'd0;
      pend_q    <= 1'b0;
      an_q      <= 8'hFF;
      ssd_q     <= 7'h7F;
      frame_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      ssd_q     <= ssd_d;
      frame_q   <= frame_d;
    end
  end

  assign scan.scan_ssd   = ssd_q;
  assign scan.scan_an    = an_q;
  assign scan.scan_frame = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed steps plus random traffic
// checked against a cycle-numbered frame model.
module tb_ssd_scan_driver;

  localparam int P = 2;
  localparam int FR = 8 * P;

  logic clk;
  logic rst_n;
  ssd_scan_if scan();

  ssd_scan_driver #(.CLK(P)) dut (
    .scan_port_clk (clk),
    .scan_port_rst (rst_n),
    .scan          (scan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  // Model: edges since reset, shown value, latest uncommitted value.
  int          n;
  logic [31:0] disp_m;
  logic [31:0] pend_v;
  bit          pend_m;

  logic [6:0] hex_t [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk8(input string tag, input logic [7:0] o,
                      input logic [7:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, o, e);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] o,
                      input logic [6:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s n=%0d got=%b exp=%b", tag, n, o, e);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    disp_m = 32'd0;
    pend_v = 32'd0;
    pend_m = 0;
  endtask

  // One clock: drive, let the edge happen, predict, then check.
  task automatic step(input logic v, input logic [31:0] d,
                      input logic b);
    int k;
    int top;
    bit off;
    bit wrp;
    logic [7:0] e_an;
    logic [6:0] e_ssd;
    scan.scan_valid = v;
    scan.scan_data  = d;
    scan.scan_blank = b;
    @(posedge clk);
    n++;
    k   = ((n - 1) / P) % 8;
    wrp = (n % FR) == 0;
    top = 0;
    for (int j = 0; j < 8; j++)
      if (disp_m[j*4 +: 4] != 0) top = j;
    off = b;
`ifdef SSD_LZ_BLANK_EN
    if (k > top) off = 1;
`endif
    e_an  = 8'hFF;
    e_ssd = 7'h7F;
    if (!off) begin
      e_an[k] = 1'b0;
      e_ssd   = hex_t[disp_m[k*4 +: 4]];
    end
    if (v) begin
      pend_v = d;
      pend_m = 1;
    end
    if (wrp && pend_m) begin
      disp_m = pend_v;
      pend_m = 0;
    end
    @(negedge clk);
    chk8("an", scan.scan_an, e_an);
    chk7("ssd", scan.scan_ssd, e_ssd);
    chk1("frame", scan.scan_frame, wrp);
    scan.scan_valid = 1'b0;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    model_reset();
    scan.scan_valid = 1'b0;
    scan.scan_data  = 32'd0;
    scan.scan_blank = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk8("rst_an", scan.scan_an, 8'hFF);
    chk7("rst_ssd", scan.scan_ssd, 7'h7F);
    chk1("rst_frame", scan.scan_frame, 1'b0);
    rst_n = 1'b1;

    // Zero display: first edge shows digit 0 = "0".
    idle(2 * FR);

    // Rotation pattern.
    step(1'b1, 32'h7654_3210, 1'b0);
    idle(2 * FR + 2);

    // Commit at a mid-frame digit only lands at the wrap.
    for (int i = 0; i < FR && ((n / P) % 8) != 3; i++) idle(1);
    step(1'b1, 32'h0000_0008, 1'b0);
    idle(2 * FR);

    // Back-to-back strobes in one frame: last wins.
    idle(P);
    step(1'b1, 32'h1111_1111, 1'b0);
    idle(P);
    step(1'b1, 32'h2222_2222, 1'b0);
    idle(2 * FR);

    // Strobe exactly on the wrap edge.
    for (int i = 0; i < FR && ((n + 1) % FR) != 0; i++) idle(1);
    step(1'b1, 32'hABCD_EF98, 1'b0);
    idle(FR + 1);

    // Blank for 5 cycles starting at digit 2.
    for (int i = 0; i < FR && ((n / P) % 8) != 2; i++) idle(1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
    idle(FR);

    // Reset mid-frame drops an uncommitted value.
    step(1'b1, 32'h5555_5555, 1'b0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk8("mrst_an", scan.scan_an, 8'hFF);
    chk7("mrst_ssd", scan.scan_ssd, 7'h7F);
    chk1("mrst_frame", scan.scan_frame, 1'b0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle(FR + 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom(),
           ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
